// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings up the system PLL and releases the resets of the clock domains it
// feeds. Each attempt pulses the PLL reset, waits for a sustained lock
// indication, then releases the domain resets one by one in index order.
// A lock timeout causes a retry (counted, saturating). Lock loss after the
// release has started, or a software request, restarts the whole sequence
// with every domain put back into reset at once.
//
// Ports
//   refclk        in   1            reference clock, the only clock
//   rst           in   1            synchronous active-high reset
//   pll_locked    in   1            PLL lock, asynchronous (2-flop synchronised)
//   sw_reset_req  in   1            single-cycle pulse: restart the sequence
//   pll_rst       out  1            PLL reset, active-high
//   domain_reset  out  NUM_DOMAINS  per-domain reset, active-high
//   ready         out  1            all domains released and lock held
//   retry_count   out  4            lock-timeout retries, saturates at 15
//   lock_lost     out  1            sticky: lock dropped after release began
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int NUM_DOMAINS    = 6,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_STABLE    = 1024,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int RELEASE_GAP    = 64
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   ready,
    output logic [3:0]             retry_count,
    output logic                   lock_lost
);

    // One shared counter serves the PLL reset pulse, the lock timeout and the
    // release gap; it is cleared on every state entry so it never wraps.
    localparam int MAX_A   = (PLL_RST_CYCLES > RELEASE_GAP) ? PLL_RST_CYCLES : RELEASE_GAP;
    localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int SW      = $clog2(LOCK_STABLE + 1);

    localparam logic [CW-1:0] PRC_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(RELEASE_GAP - 1);
    localparam logic [CW-1:0] TIMEOUT   = CW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0] STABLE    = SW'(LOCK_STABLE);
    localparam logic [NUM_DOMAINS-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [SW-1:0]          stable_reg, stable_next;
    logic [1:0]             sync_reg;
    logic                   pll_rst_reg, pll_rst_next;
    logic [NUM_DOMAINS-1:0] domain_reset_reg, domain_reset_next;
    logic                   ready_reg, ready_next;
    logic [3:0]             retry_reg, retry_next;
    logic                   lock_lost_reg, lock_lost_next;

    logic                   locked_s;
    logic                   lock_drop;
    logic [SW-1:0]          stable_inc;
    logic [CW-1:0]          cnt_inc;

    assign locked_s = sync_reg[1];

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg        <= ST_PLL_RST;
            cnt_reg          <= '0;
            stable_reg       <= '0;
            sync_reg         <= '0;
            pll_rst_reg      <= 1'b1;
            domain_reset_reg <= ALL_ONES;
            ready_reg        <= 1'b0;
            retry_reg        <= 4'd0;
            lock_lost_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            stable_reg       <= stable_next;
            sync_reg         <= {sync_reg[0], pll_locked};
            pll_rst_reg      <= pll_rst_next;
            domain_reset_reg <= domain_reset_next;
            ready_reg        <= ready_next;
            retry_reg        <= retry_next;
            lock_lost_reg    <= lock_lost_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        stable_next       = stable_reg;
        pll_rst_next      = pll_rst_reg;
        domain_reset_next = domain_reset_reg;
        ready_next        = ready_reg;
        retry_next        = retry_reg;
        lock_lost_next    = lock_lost_reg;

        cnt_inc    = cnt_reg + 1'b1;
        stable_inc = locked_s ? stable_reg + 1'b1 : '0;
        lock_drop  = ((state_reg == ST_RELEASE) || (state_reg == ST_RUN)) && !locked_s;

        if (lock_drop || sw_reset_req) begin
            // Restart: every domain goes back into reset on the same edge.
            if (lock_drop) begin
                lock_lost_next = 1'b1;
            end
            state_next        = ST_PLL_RST;
            cnt_next          = '0;
            stable_next       = '0;
            pll_rst_next      = 1'b1;
            domain_reset_next = ALL_ONES;
            ready_next        = 1'b0;
        end else begin
            case (state_reg)
                ST_PLL_RST: begin
                    if (cnt_reg == PRC_LAST) begin
                        state_next   = ST_WAIT_LOCK;
                        cnt_next     = '0;
                        stable_next  = '0;
                        pll_rst_next = 1'b0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Stable lock wins over a coincident timeout.
                    if (stable_inc == STABLE) begin
                        state_next        = ST_RELEASE;
                        cnt_next          = '0;
                        stable_next       = '0;
                        domain_reset_next = ALL_ONES << 1;
                    end else if (cnt_inc == TIMEOUT) begin
                        state_next   = ST_PLL_RST;
                        cnt_next     = '0;
                        stable_next  = '0;
                        pll_rst_next = 1'b1;
                        if (retry_reg != 4'hF) begin
                            retry_next = retry_reg + 4'd1;
                        end
                    end else begin
                        cnt_next    = cnt_inc;
                        stable_next = stable_inc;
                    end
                end
                ST_RELEASE: begin
                    // Shifting zeros in from the bottom releases domains strictly
                    // in index order; one more gap after the last one gives ready.
                    if (cnt_reg == GAP_LAST) begin
                        cnt_next = '0;
                        if (domain_reset_reg == '0) begin
                            state_next = ST_RUN;
                            ready_next = 1'b1;
                        end else begin
                            domain_reset_next = domain_reset_reg << 1;
                        end
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pll_rst      = pll_rst_reg;
    assign domain_reset = domain_reset_reg;
    assign ready        = ready_reg;
    assign retry_count  = retry_reg;
    assign lock_lost    = lock_lost_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Drives pll_reset_sequencer with directed and randomized lock / request /
// reset stimulus. A phase-level reference model (phase + time-in-phase,
// domain releases computed arithmetically) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int N   = 4;
    localparam int PRC = 4;
    localparam int LST = 8;
    localparam int LTO = 64;
    localparam int GAP = 3;

    localparam int P_PLLRST = 0;
    localparam int P_WAIT   = 1;
    localparam int P_REL    = 2;
    localparam int P_RUN    = 3;

    logic         refclk = 1'b0;
    logic         rst = 1'b1;
    logic         pll_locked = 1'b0;
    logic         sw_reset_req = 1'b0;
    logic         pll_rst;
    logic [N-1:0] domain_reset;
    logic         ready;
    logic [3:0]   retry_count;
    logic         lock_lost;
    logic [N+6:0] dut_vec;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_phase  = P_PLLRST;
    int m_t      = 0;
    int m_stable = 0;
    int m_retry  = 0;
    bit m_lost   = 1'b0;
    bit m_h1     = 1'b0;   // pll_locked one cycle ago
    bit m_h2     = 1'b0;   // pll_locked two cycles ago

    localparam logic [N+6:0] RESET_VEC = {1'b1, {N{1'b1}}, 1'b0, 4'd0, 1'b0};

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .NUM_DOMAINS   (N),
        .PLL_RST_CYCLES(PRC),
        .LOCK_STABLE   (LST),
        .LOCK_TIMEOUT  (LTO),
        .RELEASE_GAP   (GAP)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .sw_reset_req(sw_reset_req),
        .pll_rst     (pll_rst),
        .domain_reset(domain_reset),
        .ready       (ready),
        .retry_count (retry_count),
        .lock_lost   (lock_lost)
    );

    assign dut_vec = {pll_rst, domain_reset, ready, retry_count, lock_lost};

    task automatic model_step(input bit r, input bit lk, input bit sw);
        bit ls;
        bit drop;
        ls = m_h2;
        if (r) begin
            m_phase = P_PLLRST; m_t = 0; m_stable = 0;
            m_retry = 0; m_lost = 1'b0; m_h1 = 1'b0; m_h2 = 1'b0;
        end else begin
            m_h2 = m_h1;
            m_h1 = lk;
            drop = ((m_phase == P_REL) || (m_phase == P_RUN)) && !ls;
            if (drop || sw) begin
                if (drop) m_lost = 1'b1;
                m_phase = P_PLLRST;
                m_t = 0;
            end else begin
                case (m_phase)
                    P_PLLRST: begin
                        m_t++;
                        if (m_t == PRC) begin
                            m_phase = P_WAIT; m_t = 0; m_stable = 0;
                        end
                    end
                    P_WAIT: begin
                        m_t++;
                        m_stable = ls ? m_stable + 1 : 0;
                        if (m_stable == LST) begin
                            m_phase = P_REL; m_t = 0;
                        end else if (m_t == LTO) begin
                            if (m_retry < 15) m_retry++;
                            m_phase = P_PLLRST; m_t = 0;
                        end
                    end
                    P_REL: begin
                        m_t++;
                        if (m_t == N * GAP) m_phase = P_RUN;
                    end
                    default: begin
                    end
                endcase
            end
        end
    endtask

    // Domains released in RELEASE = one at entry plus one per elapsed gap.
    function automatic logic [N+6:0] exp_vec();
        logic [N-1:0] dr;
        int mask;
        dr = '1;
        if (m_phase == P_REL) begin
            mask = (1 << (m_t / GAP + 1)) - 1;
            dr = ~mask[N-1:0];
        end else if (m_phase == P_RUN) begin
            dr = '0;
        end
        return {(m_phase == P_PLLRST), dr, (m_phase == P_RUN), m_retry[3:0], m_lost};
    endfunction

    task automatic tick(input bit r, input bit lk, input bit sw);
        rst = r;
        pll_locked = lk;
        sw_reset_req = sw;
        @(posedge refclk);
        model_step(r, lk, sw);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tests++;
            if (dut_vec !== RESET_VEC) begin
                fails++;
                $display("FAIL reset_values cyc=%0d got=%b exp=%b", i, dut_vec, RESET_VEC);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_nominal();
        int t_pll = -1;
        int t_rdy = -1;
        int t_bit[N];
        for (int k = 0; k < N; k++) t_bit[k] = -1;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL nominal_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
            end
            if (pll_rst === 1'b0 && t_pll < 0) t_pll = i;
            for (int k = 0; k < N; k++)
                if (domain_reset[k] === 1'b0 && t_bit[k] < 0) t_bit[k] = i;
            if (ready === 1'b1 && t_rdy < 0) t_rdy = i;
        end
        tests++;
        if (t_pll != PRC) begin
            fails++;
            $display("FAIL nominal_pll_rst_fall got=%0d exp=%0d", t_pll, PRC);
        end
        for (int k = 0; k < N; k++) begin
            tests++;
            if (t_bit[k] != 12 + GAP * k) begin
                fails++;
                $display("FAIL nominal_bit%0d_fall got=%0d exp=%0d", k, t_bit[k], 12 + GAP * k);
            end
        end
        tests++;
        if (t_rdy != 24 || ready !== 1'b1) begin
            fails++;
            $display("FAIL nominal_ready got_cycle=%0d ready=%b exp_cycle=24 ready=1", t_rdy, ready);
        end
        $display("[TB] test_nominal: ready at cycle %0d", t_rdy);
    endtask

    task automatic test_no_lock();
        int rises = 0;
        logic prev = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 16 * 68 + 5; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL no_lock_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
            end
            if (pll_rst === 1'b1 && prev === 1'b0) rises++;
            prev = pll_rst;
            if (i == 68) begin
                tests++;
                if (retry_count !== 4'd1 || pll_rst !== 1'b1) begin
                    fails++;
                    $display("FAIL no_lock_first_retry got=%0d/%b exp=1/1", retry_count, pll_rst);
                end
            end
        end
        tests++;
        if (rises != 16 || retry_count !== 4'd15 || domain_reset !== '1) begin
            fails++;
            $display("FAIL no_lock_saturate rises=%0d retry=%0d dr=%b exp 16/15/1111",
                     rises, retry_count, domain_reset);
        end
        $display("[TB] test_no_lock: %0d retries, retry_count=%0d", rises, retry_count);
    endtask

    task automatic test_glitch();
        int t_b0 = -1;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            tick(1'b0, (i != 8), 1'b0);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL glitch_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
            end
            if (domain_reset[0] === 1'b0 && t_b0 < 0) t_b0 = i;
        end
        tests++;
        if (t_b0 != 18 || retry_count !== 4'd0) begin
            fails++;
            $display("FAIL glitch_release got=%0d retry=%0d exp=18 retry=0", t_b0, retry_count);
        end
        $display("[TB] test_glitch: bit0 released at cycle %0d", t_b0);
    endtask

    task automatic test_lock_loss();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 30; i++) tick(1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            tick(1'b0, 1'b0, 1'b0);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL loss_model cyc=%0d got=%b exp=%b", j, dut_vec, exp_vec());
            end
            if (j == 2) begin
                tests++;
                if (ready !== 1'b1) begin
                    fails++;
                    $display("FAIL loss_too_early ready=%b exp=1", ready);
                end
            end
            if (j == 3) begin
                tests++;
                if (dut_vec !== {1'b1, {N{1'b1}}, 1'b0, 4'd0, 1'b1}) begin
                    fails++;
                    $display("FAIL loss_reassert got=%b exp=%b", dut_vec,
                             {1'b1, {N{1'b1}}, 1'b0, 4'd0, 1'b1});
                end
            end
        end
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL loss_reseq_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
            end
        end
        tests++;
        if (ready !== 1'b1 || lock_lost !== 1'b1) begin
            fails++;
            $display("FAIL loss_recovered ready=%b lock_lost=%b exp 1/1", ready, lock_lost);
        end
        $display("[TB] test_lock_loss: recovered ready=%b lock_lost=%b", ready, lock_lost);
    endtask

    task automatic test_sw_release();
        int t_rdy = -1;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 15; i++) tick(1'b0, 1'b1, 1'b0);
        tests++;
        if (domain_reset !== 4'b1100) begin
            fails++;
            $display("FAIL sw_pre_state dr=%b exp=1100", domain_reset);
        end
        tick(1'b0, 1'b1, 1'b1);
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++;
            $display("FAIL sw_reassert got=%b exp=%b", dut_vec, RESET_VEC);
        end
        for (int i = 1; i <= 30; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL sw_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
            end
            if (ready === 1'b1 && t_rdy < 0) t_rdy = i;
        end
        tests++;
        if (t_rdy != 24 || lock_lost !== 1'b0) begin
            fails++;
            $display("FAIL sw_resequence ready_cycle=%0d lock_lost=%b exp 24/0", t_rdy, lock_lost);
        end
        $display("[TB] test_sw_release: ready %0d cycles after request", t_rdy);
    endtask

    task automatic test_rst_in_run();
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 70; i++) tick(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) tick(1'b0, 1'b1, 1'b0);
        tests++;
        if (ready !== 1'b1 || retry_count !== 4'd1) begin
            fails++;
            $display("FAIL rst_run_setup ready=%b retry=%0d exp 1/1", ready, retry_count);
        end
        tick(1'b1, 1'b0, 1'b0);
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++;
            $display("FAIL rst_in_run got=%b exp=%b", dut_vec, RESET_VEC);
        end
        $display("[TB] test_rst_in_run: outputs %b", dut_vec);
    endtask

    task automatic test_random();
        bit base;
        bit lk;
        bit sw;
        bit r;
        for (int rnd = 0; rnd < 6; rnd++) begin
            base = 1'b1;
            tick(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 149) == 0) base = ~base;
                lk = ($urandom_range(0, 99) < 97) ? base : ~base;
                sw = ($urandom_range(0, 199) == 0);
                r  = ($urandom_range(0, 499) == 0);
                tick(r, lk, sw);
                tests++;
                if (dut_vec !== exp_vec()) begin
                    fails++;
                    $display("FAIL random_model rnd=%0d cyc=%0d got=%b exp=%b",
                             rnd, i, dut_vec, exp_vec());
                end
                tests++;
                if (ready === 1'b1 && (pll_rst !== 1'b0 || domain_reset !== '0)) begin
                    fails++;
                    $display("FAIL random_ready_invariant pll_rst=%b dr=%b exp 0/0000",
                             pll_rst, domain_reset);
                end
            end
            $display("[TB] test_random round %0d: retry=%0d lock_lost=%b", rnd, retry_count, lock_lost);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_no_lock();
        test_glitch();
        test_lock_loss();
        test_sw_release();
        test_rst_in_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
